// File: rtl/clock_divider_pkg.sv
// Shared types and helpers for the clock divider controller, its divider core and benches.
package clock_divider_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    LOAD  = 2'd3
  } ctrl_state_t;

  function automatic int unsigned CeilLog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

  function automatic longint unsigned MaxValue(input int unsigned nbits);
    return (64'd1 << nbits) - 64'd1;
  endfunction

  // Half-period in reference-clock cycles for a requested output frequency.
  function automatic int unsigned half_period(input int unsigned ref_hz, input int unsigned out_hz);
    return ref_hz / (2 * out_hz);
  endfunction

endpackage

// File: rtl/clock_divider_ctrl_if.sv
// Configuration handshake between the CPU/config logic (master) and the divider controller (slave).
interface clock_divider_ctrl_if #(
  parameter int unsigned NBITS = 16
);
  logic             cfg_valid;
  logic [NBITS-1:0] cfg_half_period;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (output cfg_valid, output cfg_half_period, input cfg_ready, input cfg_err);
  modport slave  (input cfg_valid, input cfg_half_period, output cfg_ready, output cfg_err);
endinterface

// File: rtl/clock_divider_core.sv
// Divider counter, half-period register and toggle flop; the half-period changes only on load.
module clock_divider_core #(
  parameter int unsigned NBITS        = 16,
  parameter int unsigned DEFAULT_HALF = 2
) (
  input  logic             clk_FPGA,
  input  logic             reset,
  input  logic             run,
  input  logic             load,
  input  logic [NBITS-1:0] load_value,
  input  logic             suppress_rise,
  output logic             clock_signal,
  output logic             tick,
  output logic             terminal
);
  logic [NBITS-1:0] count;
  logic [NBITS-1:0] active_half;

  assign terminal = (count == active_half - NBITS'(1));

  always_ff @(posedge clk_FPGA or negedge reset) begin
    if (!reset) begin
      count        <= '0;
      active_half  <= NBITS'(DEFAULT_HALF);
      clock_signal <= 1'b0;
      tick         <= 1'b0;
    end else if (load) begin
      // With run set, the extended low phase ends here and the new setting starts high.
      active_half  <= load_value;
      count        <= '0;
      clock_signal <= run;
      tick         <= run;
    end else if (run) begin
      tick <= 1'b0;
      if (terminal) begin
        count <= '0;
        if (clock_signal) begin
          clock_signal <= 1'b0;
        end else if (!suppress_rise) begin
          clock_signal <= 1'b1;
          tick         <= 1'b1;
        end
      end else begin
        count <= count + NBITS'(1);
      end
    end else begin
      count        <= '0;
      clock_signal <= 1'b0;
      tick         <= 1'b0;
    end
  end
endmodule

// File: rtl/clock_divider_ctrl.sv
// Runtime controller for the divided clock: cfg handshake, pending setting, glitch-free switchover.
// Optional feature: define CLKDIV_CTRL_PERIOD_CNT_EN to add the period_count output.
//
// state | meaning
// IDLE  | divider stopped, clock_signal 0, cfg accepted
// RUN   | divider running, cfg accepted
// DRAIN | old setting runs to the end of a low phase, cfg pending
// LOAD  | pending half-period applied, counter restarted
module clock_divider_ctrl
  import clock_divider_pkg::*;
#(
  parameter int unsigned REFERENCE_CLOCK   = 50_000_000,
  parameter int unsigned DEFAULT_FREQUENCY = 12_500_000,
  parameter int unsigned NBITS_FOR_COUNTER = 16,
  parameter int unsigned DEFAULT_HALF      = half_period(REFERENCE_CLOCK, DEFAULT_FREQUENCY)
) (
  input  logic                 clk_FPGA,
  input  logic                 reset,
  input  logic                 enable,
  clock_divider_ctrl_if.slave  cfg,
  output logic                 clock_signal,
  output logic                 tick,
  output logic                 busy
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
  ,
  output logic [31:0]          period_count
`endif
);
  ctrl_state_t                  state, state_next;
  logic [NBITS_FOR_COUNTER-1:0] pending;
  logic                         accept, take, cfg_err_q;
  logic                         run, load, suppress_rise, terminal;

  assign cfg.cfg_ready = (state == IDLE) || (state == RUN);
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;
  assign take          = accept && (cfg.cfg_half_period != '0);
  assign cfg.cfg_err   = cfg_err_q;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk_FPGA or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pending   <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state     <= state_next;
      cfg_err_q <= accept && (cfg.cfg_half_period == '0);
      if (take) pending <= cfg.cfg_half_period;
    end
  end

  always_comb begin
    state_next    = state;
    run           = 1'b0;
    load          = 1'b0;
    suppress_rise = 1'b0;
    case (state)
      IDLE: begin
        if (take)        state_next = LOAD;
        else if (enable) state_next = RUN;
      end
      RUN: begin
        run = 1'b1;
        if (take) begin
          state_next = DRAIN;
        end else if (!enable) begin
          if (!clock_signal) begin
            run        = 1'b0;
            state_next = IDLE;
          end else if (terminal) begin
            state_next = IDLE;
          end
        end
      end
      DRAIN: begin
        run           = 1'b1;
        suppress_rise = 1'b1;
        if (terminal && !clock_signal) state_next = LOAD;
      end
      LOAD: begin
        load       = 1'b1;
        run        = enable;
        state_next = enable ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  clock_divider_core #(
    .NBITS        (NBITS_FOR_COUNTER),
    .DEFAULT_HALF (DEFAULT_HALF)
  ) u_core (
    .clk_FPGA      (clk_FPGA),
    .reset         (reset),
    .run           (run),
    .load          (load),
    .load_value    (pending),
    .suppress_rise (suppress_rise),
    .clock_signal  (clock_signal),
    .tick          (tick),
    .terminal      (terminal)
  );

`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
  always_ff @(posedge clk_FPGA or negedge reset) begin
    if (!reset)     period_count <= '0;
    else if (load)  period_count <= '0;
    else if (tick)  period_count <= period_count + 32'd1;
  end
`endif
endmodule
